// File: rtl/operand_loader_pkg.sv
// operand_loader_pkg: shared state encoding and widths for the operand loader.
`default_nettype none

package operand_loader_pkg;

  localparam int STAGE_W     = 2;
  localparam int ADDER_WIDTH = 8;

  typedef enum logic [STAGE_W-1:0] {
    S_A    = 2'd0,
    S_B    = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage : operand_loader_pkg

`default_nettype wire

// File: rtl/operand_loader_btn_sync.sv
// btn_sync: 2-flop synchroniser, optional debounce, rising-edge press pulse.
// Debounce compiled in with OPERAND_LOADER_DEBOUNCE_EN.
`default_nettype none

module btn_sync #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic Clk,
  input  logic Clear,
  input  logic Btn_in,
  output logic Press
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;
  logic level;

  // Everything resets high so a button held across reset release is not a press.
  always_ff @(posedge Clk or negedge Clear) begin
    if (!Clear) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= Btn_in;
      sync2_q <= sync1_q;
    end
  end

`ifdef OPERAND_LOADER_DEBOUNCE_EN
  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;

  // Counter only survives consecutive mismatch cycles; the level flips on the last one.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Clear) begin
    if (!Clear) begin
      cnt_q   <= '0;
      level_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level = level_q;
`else
  logic unused_debounce_cfg;
  assign unused_debounce_cfg = ^DEBOUNCE_CYCLES;
  assign level = sync2_q;
`endif

  always_ff @(posedge Clk or negedge Clear) begin
    if (!Clear) begin
      prev_q <= 1'b1;
    end else begin
      prev_q <= level;
    end
  end

  assign Press = level & ~prev_q;

endmodule : btn_sync

`default_nettype wire

// File: rtl/operand_loader.sv
// operand_loader: captures two switch operands on Enter presses, Back undoes.
// Optional debounce via OPERAND_LOADER_DEBOUNCE_EN.
`default_nettype none

module operand_loader
  import operand_loader_pkg::*;
#(
  parameter int WIDTH           = ADDER_WIDTH,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic               Clk,
  input  logic               Clear,
  input  logic [WIDTH-1:0]   Sw,
  input  logic               Enter,
  input  logic               Back,
  output logic [WIDTH-1:0]   Data1,
  output logic [WIDTH-1:0]   Data2,
  output logic               Valid,
  output logic [STAGE_W-1:0] Stage
);

  logic enter_press;
  logic back_press;

  btn_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
    .Clk    (Clk),
    .Clear  (Clear),
    .Btn_in (Enter),
    .Press  (enter_press)
  );

  btn_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_back (
    .Clk    (Clk),
    .Clear  (Clear),
    .Btn_in (Back),
    .Press  (back_press)
  );

  state_t           state_q;
  logic [WIDTH-1:0] data1_q;
  logic [WIDTH-1:0] data2_q;
  logic             valid_q;

  // Back is checked first in every state so a simultaneous Enter is dropped.
  always_ff @(posedge Clk or negedge Clear) begin
    if (!Clear) begin
      state_q <= S_A;
      data1_q <= '0;
      data2_q <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_A: begin
          if (enter_press && !back_press) begin
            data1_q <= Sw;
            state_q <= S_B;
          end
        end
        S_B: begin
          if (back_press) begin
            state_q <= S_A;
          end else if (enter_press) begin
            data2_q <= Sw;
            valid_q <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          if (back_press) begin
            valid_q <= 1'b0;
            state_q <= S_B;
          end else if (enter_press) begin
            data1_q <= Sw;
            valid_q <= 1'b0;
            state_q <= S_B;
          end
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= S_A;
        end
      endcase
    end
  end

  assign Data1 = data1_q;
  assign Data2 = data2_q;
  assign Valid = valid_q;
  assign Stage = state_q;

endmodule : operand_loader

`default_nettype wire
